// File: rtl/jam_cost_scheduler_if.sv
// Handshake bundle between the permutation-search engines, the cost ROM and
// the scheduler. The master side is the engine/ROM environment.
interface jam_cost_scheduler_if #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
);
  logic [N_REQ-1:0]    req;
  logic [24*N_REQ-1:0] perm;
  logic [2:0]          W;
  logic [2:0]          J;
  logic [6:0]          Cost;
  logic [N_REQ-1:0]    gnt;
  logic                busy;
  logic                sum_valid;
  logic [9:0]          sum_out;
  logic [ID_W-1:0]     sum_id;
  logic                sum_err;

  modport master (
    output req, perm, Cost,
    input  W, J, gnt, busy, sum_valid, sum_out, sum_id, sum_err
  );

  modport slave (
    input  req, perm, Cost,
    output W, J, gnt, busy, sum_valid, sum_out, sum_id, sum_err
  );
endinterface

// File: rtl/jam_cost_scheduler.sv
// Shares the cost-ROM lookup port among N_REQ search engines. A granted
// engine's 8-entry permutation is swept W=0..7 with J=perm[W] and the eight
// Cost values are summed; the total comes back tagged with the engine ID.
//
// state | meaning
// IDLE  | sample requests, arbitrate round-robin, capture the winner's perm
// ISSUE | 8 cycles driving W/J and accumulating Cost
// DONE  | one-cycle sum_valid pulse with the result (or error code 1023)
//
// Requests are registered in IDLE before arbitration, so IDLE always lasts at
// least two cycles; a requester still high after its sum_valid is re-sampled.
module jam_cost_scheduler #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input logic              CLK,
  input logic              RST,
  jam_cost_scheduler_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] req_q, req_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [23:0]      perm_q, perm_d;
  logic [2:0]       idx_q, idx_d;
  logic [9:0]       acc_q, acc_d;
  logic [9:0]       sum_out_q, sum_out_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]  sum_id_q, sum_id_d;
  logic             busy_q, busy_d;
  logic             sv_q, sv_d;
  logic             err_q, err_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW:0]      cand;
  logic [23:0]      win_perm;
  logic [7:0]       seen;
  logic             win_ok;
  logic [4:0]       jbase;

  // Round-robin search over the registered requests, starting at rr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!found && req_q[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  // Winner's perm and its permutation check: all eight fields distinct
  // exactly when every job index 0..7 is hit once.
  always_comb begin
    win_perm = '0;
    seen     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == PW'(k)) win_perm = bus.perm[24*k +: 24];
    end
    for (int w = 0; w < 8; w++) begin
      seen[win_perm[3*w +: 3]] = 1'b1;
    end
  end
  assign win_ok = &seen;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    req_d     = '0;
    gnt_d     = gnt_q;
    perm_d    = perm_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sum_out_d = sum_out_q;
    rr_d      = rr_q;
    sum_id_d  = sum_id_q;
    sv_d      = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          perm_d   = win_perm;
          sum_id_d = ID_W'(win);
          rr_d     = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
          idx_d    = '0;
          if (win_ok) begin
            state_d    = ISSUE;
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            err_d      = 1'b0;
          end else begin
            // Error path leaves acc alone and reports the reserved total.
            state_d   = DONE;
            err_d     = 1'b1;
            sum_out_d = 10'd1023;
            sv_d      = 1'b1;
          end
        end else begin
          req_d = bus.req;
        end
      end
      ISSUE: begin
        acc_d = (idx_q == 3'd0) ? {3'b000, bus.Cost} : acc_q + {3'b000, bus.Cost};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d   = DONE;
          gnt_d     = '0;
          sum_out_d = acc_d;
          sv_d      = 1'b1;
          err_d     = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      req_q     <= '0;
      gnt_q     <= '0;
      perm_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      sum_out_q <= '0;
      rr_q      <= '0;
      sum_id_q  <= '0;
      busy_q    <= 1'b0;
      sv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      gnt_q     <= gnt_d;
      perm_q    <= perm_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sum_out_q <= sum_out_d;
      rr_q      <= rr_d;
      sum_id_q  <= sum_id_d;
      busy_q    <= busy_d;
      sv_q      <= sv_d;
      err_q     <= err_d;
    end
  end

  assign jbase = {idx_q, 1'b0} + {2'b00, idx_q};
  assign bus.W = (state_q == ISSUE) ? idx_q : 3'd0;
  assign bus.J = (state_q == ISSUE) ? perm_q[jbase +: 3] : 3'd0;

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.sum_valid = sv_q;
  assign bus.sum_out   = sum_out_q;
  assign bus.sum_id    = sum_id_q;
  assign bus.sum_err   = err_q;
endmodule
